alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the 16-bit ALU.
- Accepts a decoded instruction over valid/ready and selects operand A/B: register value, bypass, or immediate.
- Generates the 3-bit ALU function select and registers everything.
- Presents stable a/b/alu_control to the ALU one cycle after acceptance; holds under back-pressure.

Parameters:
- DATA_W, 16, operand/result width.
- REG_AW, 3, register index width (8 registers; r0 reads as zero).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of held/incoming instruction.
- in_valid  in  1  decode offers instruction.
- in_ready  out  1  stage can accept.
- in_rs1  in  REG_AW  source 1 index.
- in_rs2  in  REG_AW  source 2 index.
- in_rs1_val  in  DATA_W  register-file read 1.
- in_rs2_val  in  DATA_W  register-file read 2.
- in_imm  in  DATA_W  sign-extended immediate.
- in_alu_src  in  1  1 = operand B from in_imm.
- in_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 slt-immediate.
- in_funct  in  3  R-type function field.
- in_rd  in  REG_AW  destination index.
- in_reg_write  in  1  destination write enable.
- exm_wen  in  1  EX/MEM stage writes a register.
- exm_rd  in  REG_AW  EX/MEM destination.
- exm_data  in  DATA_W  EX/MEM result.
- wb_wen  in  1  writeback stage writes a register.
- wb_rd  in  REG_AW  writeback destination.
- wb_data  in  DATA_W  writeback data.
- out_valid  out  1  operands valid to ALU.
- out_ready  in  1  downstream consumes.
- alu_a  out  DATA_W  ALU src1.
- alu_b  out  DATA_W  ALU src2.
- alu_control  out  3  ALU function select.
- out_rd  out  REG_AW  destination, passed through.
- out_reg_write  out  1  write enable, passed through.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, alu_a=0, alu_b=0, alu_control=3'b000, out_rd=0, out_reg_write=0, internal held indices=0, imm flag=0.
- in_ready = !out_valid || out_ready (combinational, no bubble).
- Capture on clk edge when in_valid && in_ready && !flush; out_valid=1 next cycle. Latency: 1 cycle.
- Pop when out_valid && out_ready with no new capture: out_valid=0.
- Operand select at capture, per source:
  - index 0 -> 0.
  - else exm_wen && exm_rd==idx -> exm_data.
  - else wb_wen && wb_rd==idx -> wb_data.
  - else the register-file value.
  - EX/MEM has priority over WB.
- in_alu_src=1 -> alu_b=in_imm. No forwarding on B; rs2 is still recorded.
- Hold refresh: while out_valid && !out_ready, each cycle that wb_wen && wb_rd==held index (index != 0) reloads that operand with wb_data. Same rule with exm on priority over wb. Never applies to an immediate B.
- alu_control decode:
  - op 00 -> 000 (add).
  - op 01 -> 001 (sub).
  - op 11 -> 100 (slt).
  - op 10 -> funct if funct is 000..100, else 000.
- flush=1: out_valid=0 next edge; no capture that cycle. Flush has priority over capture and hold. Data registers may keep stale values.
- Accepting while popping the same cycle: new instruction replaces old; out_valid stays 1.
- in_reg_write with in_rd==0 is passed through unchanged; suppression happens at writeback.
- Reset mid-hold: instruction is lost, outputs return to reset values immediately.
- All arithmetic is selection only; no width changes; DATA_W bits preserved.

Decomposition:
- Shared package cpu_pkg:
  - ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b100.
  - ALUOP_* encodings for in_alu_op.
  - DATA_W/REG_AW defaults.
- One natural sub-module: fwd_mux (combinational per-operand bypass select: index, exm, wb, regfile value -> operand). Instantiated twice for capture and reused for hold refresh.

Test Plan:
- Reset then in_valid with rs1=2 (val 0x0005), rs2=3 (val 0x0007), op=10, funct=000, out_ready=1 -> next cycle out_valid=1, alu_a=0x0005, alu_b=0x0007, alu_control=000.
- Capture with rs1=4, exm_wen=1/exm_rd=4/exm_data=0x1234, wb_wen=1/wb_rd=4/wb_data=0xBEEF -> alu_a=0x1234 (EX/MEM priority). Repeat with rs1=0 -> alu_a=0x0000.
- op=01, alu_src=1, imm=0xFFFE -> alu_control=001, alu_b=0xFFFE. op=10 with funct=111 -> alu_control=000.
- out_ready=0 for 3 cycles holding rs2=5; in cycle 2 wb_wen=1, wb_rd=5, wb_data=0x00AA -> alu_b becomes 0x00AA, in_ready=0 throughout, out_valid stays 1.
- Back-to-back: in_valid and out_ready both high for 4 cycles -> 4 results on consecutive cycles, no bubbles. Flush asserted while holding -> out_valid=0 next cycle, in_ready=1.
- Assert rst_n=0 mid-hold asynchronously (between edges) -> out_valid, alu_a, alu_b, alu_control go to 0 without a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: ALU function selects, ALU-op classes, default widths.
// No latency (constants and pure functions only).
// No flow control (nothing here is clocked).
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_REG_AW = 3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLTI  = 2'b11;

    // Undefined R-type funct codes fall back to add so the ALU never sees garbage.
    function automatic logic [2:0] alu_decode(input logic [1:0] op, input logic [2:0] funct);
        logic [2:0] ctl;
        ctl = ALU_ADD;
        case (op)
            ALUOP_ADD:   ctl = ALU_ADD;
            ALUOP_SUB:   ctl = ALU_SUB;
            ALUOP_SLTI:  ctl = ALU_SLT;
            ALUOP_RTYPE: ctl = (funct <= ALU_SLT) ? funct : ALU_ADD;
            default:     ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: r0 -> zero, then EX/MEM, then WB, then fallback value.
// Latency: combinational.
// No flow control; caller decides when the result is registered.
module fwd_mux #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] idx_i,
    input  logic [DATA_W-1:0] rf_val_i,
    input  logic              exm_wen_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic [DATA_W-1:0] exm_data_i,
    input  logic              wb_wen_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] opnd_o
);

    always_comb begin
        opnd_o = rf_val_i;
        if (idx_i == '0)
            opnd_o = '0;
        else if (exm_wen_i && (exm_rd_i == idx_i))
            opnd_o = exm_data_i;
        else if (wb_wen_i && (wb_rd_i == idx_i))
            opnd_o = wb_data_i;
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage: selects and registers ALU operands and function select.
// Latency: 1 cycle from acceptance to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; held operands track bypass writes.
module alu_operand_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int REG_AW = CPU_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_rs1_val,
    input  logic [DATA_W-1:0] in_rs2_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_alu_src,
    input  logic [1:0]        in_alu_op,
    input  logic [2:0]        in_funct,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic              exm_wen,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_control_q, alu_control_d;
    logic [REG_AW-1:0] out_rd_q, out_rd_d;
    logic              out_reg_write_q, out_reg_write_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic              imm_q, imm_d;

    logic              hold;
    logic              capture;
    logic [REG_AW-1:0] sel_idx_a, sel_idx_b;
    logic [DATA_W-1:0] sel_val_a, sel_val_b;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    assign in_ready = !out_valid_q || out_ready;
    assign hold     = out_valid_q && !out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Capture and hold refresh never happen in the same cycle, so one mux pair serves both;
    // while holding, the held value is the fallback so no match leaves it unchanged.
    assign sel_idx_a = hold ? rs1_q   : in_rs1;
    assign sel_val_a = hold ? alu_a_q : in_rs1_val;
    assign sel_idx_b = hold ? rs2_q   : in_rs2;
    assign sel_val_b = hold ? alu_b_q : in_rs2_val;

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .idx_i      (sel_idx_a),
        .rf_val_i   (sel_val_a),
        .exm_wen_i  (exm_wen),
        .exm_rd_i   (exm_rd),
        .exm_data_i (exm_data),
        .wb_wen_i   (wb_wen),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .opnd_o     (fwd_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .idx_i      (sel_idx_b),
        .rf_val_i   (sel_val_b),
        .exm_wen_i  (exm_wen),
        .exm_rd_i   (exm_rd),
        .exm_data_i (exm_data),
        .wb_wen_i   (wb_wen),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .opnd_o     (fwd_b)
    );

    always_comb begin
        out_valid_d     = out_valid_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        alu_control_d   = alu_control_q;
        out_rd_d        = out_rd_q;
        out_reg_write_d = out_reg_write_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        imm_d           = imm_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d     = 1'b1;
            alu_a_d         = fwd_a;
            alu_b_d         = in_alu_src ? in_imm : fwd_b;
            alu_control_d   = alu_decode(in_alu_op, in_funct);
            out_rd_d        = in_rd;
            out_reg_write_d = in_reg_write;
            rs1_d           = in_rs1;
            rs2_d           = in_rs2;
            imm_d           = in_alu_src;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else if (hold) begin
            alu_a_d = fwd_a;
            if (!imm_q)
                alu_b_d = fwd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_control_q   <= ALU_ADD;
            out_rd_q        <= '0;
            out_reg_write_q <= 1'b0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            imm_q           <= 1'b0;
        end else begin
            out_valid_q     <= out_valid_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            alu_control_q   <= alu_control_d;
            out_rd_q        <= out_rd_d;
            out_reg_write_q <= out_reg_write_d;
            rs1_q           <= rs1_d;
            rs2_q           <= rs2_d;
            imm_q           <= imm_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_control   = alu_control_q;
    assign out_rd        = out_rd_q;
    assign out_reg_write = out_reg_write_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised and directed checks of alu_operand_stage against a transaction-level model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [2:0]  in_rs1, in_rs2, in_rd;
    logic [15:0] in_rs1_val, in_rs2_val, in_imm;
    logic        in_alu_src, in_reg_write;
    logic [1:0]  in_alu_op;
    logic [2:0]  in_funct;
    logic        exm_wen, wb_wen;
    logic [2:0]  exm_rd, wb_rd;
    logic [15:0] exm_data, wb_data;
    logic        out_valid, out_ready;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_control, out_rd;
    logic        out_reg_write;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_funct(in_funct),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: the instruction currently presented to the ALU.
    logic        m_vld;
    logic [15:0] m_a, m_b;
    logic [2:0]  m_ctl, m_rd, m_rs1, m_rs2;
    logic        m_rw, m_imm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_opnd(input logic [2:0] idx, input logic [15:0] fallback);
        if (idx == 3'd0) return 16'h0000;
        if (exm_wen && exm_rd == idx) return exm_data;
        if (wb_wen && wb_rd == idx) return wb_data;
        return fallback;
    endfunction

    function automatic logic [2:0] ref_ctl(input logic [1:0] op, input logic [2:0] funct);
        case (op)
            2'd0: return 3'd0;
            2'd1: return 3'd1;
            2'd3: return 3'd4;
            default: return (funct < 3'd5) ? funct : 3'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_vld = 0; m_a = 0; m_b = 0; m_ctl = 0; m_rd = 0; m_rw = 0;
        m_rs1 = 0; m_rs2 = 0; m_imm = 0;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_val = 0; in_rs2_val = 0;
        in_imm = 0; in_alu_src = 0; in_alu_op = 0; in_funct = 0; in_rd = 0; in_reg_write = 0;
        exm_wen = 0; exm_rd = 0; exm_data = 0; wb_wen = 0; wb_rd = 0; wb_data = 0;
        out_ready = 1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_vld"}, out_valid, m_vld);
        if (m_vld) begin
            chk({tag, "_a"}, alu_a, m_a);
            chk({tag, "_b"}, alu_b, m_b);
            chk({tag, "_ctl"}, alu_control, m_ctl);
            chk({tag, "_rd"}, out_rd, m_rd);
            chk({tag, "_rw"}, out_reg_write, m_rw);
        end
    endtask

    // Inputs are set by the caller; this checks in_ready, advances the model, clocks and checks outputs.
    task automatic step(input string tag);
        logic rdy;
        #1;
        rdy = !m_vld || out_ready;
        chk({tag, "_irdy"}, in_ready, rdy);
        if (flush) begin
            m_vld = 0;
        end else if (in_valid && rdy) begin
            m_vld = 1;
            m_a   = ref_opnd(in_rs1, in_rs1_val);
            m_b   = in_alu_src ? in_imm : ref_opnd(in_rs2, in_rs2_val);
            m_ctl = ref_ctl(in_alu_op, in_funct);
            m_rd  = in_rd; m_rw = in_reg_write;
            m_rs1 = in_rs1; m_rs2 = in_rs2; m_imm = in_alu_src;
        end else if (m_vld && out_ready) begin
            m_vld = 0;
        end else if (m_vld) begin
            m_a = ref_opnd(m_rs1, m_a);
            if (!m_imm) m_b = ref_opnd(m_rs2, m_b);
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", out_valid, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_ctl", alu_control, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_rw", out_reg_write, 0);
        chk("rst_irdy", in_ready, 1);
        rst_n = 1;

        // Basic R-type add from the register file
        in_valid = 1; in_rs1 = 2; in_rs1_val = 16'h0005; in_rs2 = 3; in_rs2_val = 16'h0007;
        in_alu_op = 2'b10; in_funct = 3'b000; in_rd = 1; in_reg_write = 1;
        step("tp_basic");
        chk("tp_basic_vld1", out_valid, 1);
        chk("tp_basic_a5", alu_a, 16'h0005);
        chk("tp_basic_b7", alu_b, 16'h0007);
        chk("tp_basic_ctl0", alu_control, 3'b000);

        // EX/MEM beats WB on a double match; r0 is always zero
        in_rs1 = 4; in_rs1_val = 16'h4444;
        exm_wen = 1; exm_rd = 4; exm_data = 16'h1234;
        wb_wen = 1; wb_rd = 4; wb_data = 16'hBEEF;
        step("tp_prio");
        chk("tp_prio_a", alu_a, 16'h1234);
        in_rs1 = 0; in_rs1_val = 16'h7777; exm_rd = 0; wb_rd = 0;
        step("tp_r0");
        chk("tp_r0_a", alu_a, 16'h0000);
        exm_wen = 0; wb_wen = 0;

        // Immediate B with sub, then an undefined funct
        in_alu_op = 2'b01; in_alu_src = 1; in_imm = 16'hFFFE; in_rs2 = 6; in_rs2_val = 16'h0606;
        step("tp_imm");
        chk("tp_imm_ctl", alu_control, 3'b001);
        chk("tp_imm_b", alu_b, 16'hFFFE);
        in_alu_op = 2'b10; in_funct = 3'b111; in_alu_src = 0;
        step("tp_f7");
        chk("tp_f7_ctl", alu_control, 3'b000);
        in_alu_op = 2'b11;
        step("tp_slt");
        chk("tp_slt_ctl", alu_control, 3'b100);

        // Hold for three cycles, WB refresh of held rs2 on the second
        in_alu_op = 2'b00; in_rs1 = 1; in_rs1_val = 16'h0101; in_rs2 = 5; in_rs2_val = 16'h0011;
        step("tp_hcap");
        chk("tp_hcap_b", alu_b, 16'h0011);
        in_rs2 = 2; in_rs2_val = 16'h2222; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            wb_wen = (i == 1); wb_rd = 5; wb_data = 16'h00AA;
            #1 chk("tp_hold_irdy0", in_ready, 0);
            step("tp_hold");
            chk("tp_hold_vld1", out_valid, 1);
        end
        wb_wen = 0;
        chk("tp_hold_b", alu_b, 16'h00AA);

        // Back-to-back, no bubbles
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_rs1 = 3; in_rs1_val = 16'h1000 + 16'(i);
            step("tp_b2b");
            chk("tp_b2b_vld", out_valid, 1);
            chk("tp_b2b_a", alu_a, 16'h1000 + 16'(i));
        end

        // Flush while holding
        out_ready = 0;
        step("tp_fhold");
        flush = 1;
        step("tp_flush");
        chk("tp_flush_vld0", out_valid, 0);
        flush = 0;
        #1 chk("tp_flush_irdy1", in_ready, 1);

        // Asynchronous reset in the middle of a hold
        in_valid = 1; in_rs1 = 7; in_rs1_val = 16'h5A5A; in_alu_op = 2'b11; out_ready = 1;
        step("tp_arcap");
        out_ready = 0; in_valid = 0;
        step("tp_arhold");
        #2 rst_n = 0;
        #1;
        chk("tp_arst_vld", out_valid, 0);
        chk("tp_arst_a", alu_a, 0);
        chk("tp_arst_b", alu_b, 0);
        chk("tp_arst_ctl", alu_control, 0);
        chk("tp_arst_rw", out_reg_write, 0);
        model_reset();
        idle();
        @(posedge clk);
        #1 rst_n = 1;

        // Randomised traffic with dense index collisions
        for (int n = 0; n < 400; n++) begin
            flush        = ($urandom_range(0, 15) == 0);
            in_valid     = ($urandom_range(0, 9) < 7);
            out_ready    = ($urandom_range(0, 9) < 6);
            in_rs1       = 3'($urandom_range(0, 7));
            in_rs2       = 3'($urandom_range(0, 7));
            in_rs1_val   = 16'($urandom);
            in_rs2_val   = 16'($urandom);
            in_imm       = 16'($urandom);
            in_alu_src   = 1'($urandom_range(0, 1));
            in_alu_op    = 2'($urandom_range(0, 3));
            in_funct     = 3'($urandom_range(0, 7));
            in_rd        = 3'($urandom_range(0, 7));
            in_reg_write = 1'($urandom_range(0, 1));
            exm_wen      = 1'($urandom_range(0, 1));
            exm_rd       = 3'($urandom_range(0, 7));
            exm_data     = 16'($urandom);
            wb_wen       = 1'($urandom_range(0, 1));
            wb_rd        = 3'($urandom_range(0, 7));
            wb_data      = 16'($urandom);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
